// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch timer: FSM state encoding and BCD digit limits.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] ONES_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX = 3'd5;

endpackage

// File: rtl/timer_ctrl_mod60.sv
// mod60: enable-gated BCD counter 00-59 with synchronous clear; tc flags the 59->00 step.
module mod60 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [6:0] count,
  output logic       tc
);
  import timer_pkg::*;

  logic [3:0] ones_q, ones_d;
  logic [2:0] tens_q, tens_d;

  // Comparisons use >= so an out-of-range digit can only ever step back to zero.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 3'd0;
    end else if (en) begin
      if (ones_q >= ONES_MAX) begin
        ones_d = 4'd0;
        tens_d = (tens_q >= TENS_MAX) ? 3'd0 : tens_q + 3'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 4'd0;
      tens_q <= 3'd0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign count = {tens_q, ones_q};
  assign tc    = en && (ones_q == ONES_MAX) && (tens_q == TENS_MAX);

endmodule

// File: rtl/timer_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, 1 s prescaler and MM:SS BCD counters.
// Lap display freeze is built only when TIMER_CTRL_LAP_EN is defined.
module timer_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic       running,
  output logic [6:0] sec_bcd,
  output logic [6:0] min_bcd,
  output logic       rollover,
  output logic       frozen
);
  import timer_pkg::*;

  localparam int            PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          rollover_q, rollover_d;
  logic          clr_all, run_st, tick;
  logic          sec_tc, min_tc;
  logic [6:0]    sec_live, min_live;

  // Clear is honoured only from PAUSE and beats a coincident start_stop.
  always_comb begin
    state_d = state_q;
    clr_all = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_stop) state_d = ST_RUN;
      ST_RUN:   if (start_stop) state_d = ST_PAUSE;
      ST_PAUSE: begin
        if (clear) begin
          state_d = ST_IDLE;
          clr_all = 1'b1;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign run_st  = (state_q == ST_RUN);
  assign tick    = run_st && (presc_q == PRESC_MAX);
  assign running = run_st;

  always_comb begin
    presc_d    = presc_q;
    rollover_d = min_tc;
    if (clr_all) begin
      presc_d = '0;
    end else if (run_st) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      rollover_q <= rollover_d;
    end
  end

  assign rollover = rollover_q;

  mod60 u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_all),
    .en    (tick),
    .count (sec_live),
    .tc    (sec_tc)
  );

  mod60 u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_all),
    .en    (sec_tc),
    .count (min_live),
    .tc    (min_tc)
  );

`ifdef TIMER_CTRL_LAP_EN
  logic       frozen_q, frozen_d;
  logic [6:0] snap_sec_q, snap_sec_d;
  logic [6:0] snap_min_q, snap_min_d;

  // The snapshot is the value on display during the lap cycle; counting carries on underneath.
  always_comb begin
    frozen_d   = frozen_q;
    snap_sec_d = snap_sec_q;
    snap_min_d = snap_min_q;
    if (clr_all) begin
      frozen_d = 1'b0;
    end else if (lap && (state_q != ST_IDLE)) begin
      frozen_d   = !frozen_q;
      snap_sec_d = sec_live;
      snap_min_d = min_live;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_q   <= 1'b0;
      snap_sec_q <= 7'h00;
      snap_min_q <= 7'h00;
    end else begin
      frozen_q   <= frozen_d;
      snap_sec_q <= snap_sec_d;
      snap_min_q <= snap_min_d;
    end
  end

  assign frozen  = frozen_q;
  assign sec_bcd = frozen_q ? snap_sec_q : sec_live;
  assign min_bcd = frozen_q ? snap_min_q : min_live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign frozen     = 1'b0;
  assign sec_bcd    = sec_live;
  assign min_bcd    = min_live;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl at TICK_DIV=4; exercises lap freeze when TIMER_CTRL_LAP_EN is defined.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic       running, rollover, frozen;
  logic [6:0] sec_bcd, min_bcd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    int          k;
    logic [16:0] v;
  } exp_t;

  exp_t exp_q[$];

  // Observed vector: {running, rollover, frozen, min_bcd, sec_bcd}
  logic [16:0] obs;
  assign obs = {running, rollover, frozen, min_bcd, sec_bcd};

  timer_ctrl #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .running    (running),
    .sec_bcd    (sec_bcd),
    .min_bcd    (min_bcd),
    .rollover   (rollover),
    .frozen     (frozen)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] to_bcd(int n);
    logic [6:0] r;
    r[6:4] = 3'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [16:0] mk(logic r, logic ro, logic f, int m, int s);
    return {r, ro, f, to_bcd(m), to_bcd(s)};
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // After this returns the DUT has just entered RUN with the prescaler at 0.
  task automatic start_run();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n      = 1'b0;
    start_stop = 1'b1;
    exp_q.push_back('{"reset_hold", 0, mk(0, 0, 0, 0, 0)});
    step(2);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    start_stop = 1'b0;
    rst_n      = 1'b1;
    exp_q.push_back('{"reset_release", 0, mk(0, 0, 0, 0, 0)});
    step(2);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_start_count();
    exp_t e;
    do_reset();
    step(4);
    start_stop = 1'b1;
    exp_q.push_back('{"start_running", 0, mk(1, 0, 0, 0, 0)});
    @(negedge clk);
    start_stop = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    exp_q.push_back('{"before_first_tick", 3, mk(1, 0, 0, 0, 0)});
    exp_q.push_back('{"first_tick", 4, mk(1, 0, 0, 0, 1)});
    exp_q.push_back('{"second_tick", 8, mk(1, 0, 0, 0, 2)});
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (exp_q.size() != 0 && exp_q[0].k == k) begin
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
      end
    end
  endtask

  task automatic test_minute_carry();
    exp_t e;
    do_reset();
    start_run();
    exp_q.push_back('{"at_00_59", 239, mk(1, 0, 0, 0, 59)});
    exp_q.push_back('{"carry_01_00", 240, mk(1, 0, 0, 1, 0)});
    for (int k = 1; k <= 240; k++) begin
      step(1);
      if (exp_q.size() != 0 && exp_q[0].k == k) begin
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
      end
    end
  endtask

  task automatic test_rollover();
    exp_t e;
    int   roll_seen = 0;
    do_reset();
    start_run();
    for (int m = 1; m <= 59; m++) exp_q.push_back('{"minute_step", 240 * m, mk(1, 0, 0, m, 0)});
    exp_q.push_back('{"at_59_59", 14399, mk(1, 0, 0, 59, 59)});
    for (int k = 1; k <= 14399; k++) begin
      step(1);
      if (rollover === 1'b1) roll_seen++;
      if (exp_q.size() != 0 && exp_q[0].k == k) begin
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
      end
    end
    checks++;
    if (roll_seen != 0) begin errors++; $display("[TB] FAIL early_rollover: got %0d pulses want 0", roll_seen); end
    exp_q.push_back('{"wrap_00_00", 14400, mk(1, 1, 0, 0, 0)});
    exp_q.push_back('{"rollover_drop", 14401, mk(1, 0, 0, 0, 0)});
    exp_q.push_back('{"after_wrap_tick", 14404, mk(1, 0, 0, 0, 1)});
    for (int k = 14400; k <= 14404; k++) begin
      step(1);
      if (exp_q.size() != 0 && exp_q[0].k == k) begin
        e = exp_q.pop_front(); checks++;
        if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
      end
    end
  endtask

  task automatic test_pause_resume_clear();
    exp_t e;
    do_reset();
    start_run();
    step(13);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    exp_q.push_back('{"paused_00_03", 0, mk(0, 0, 0, 0, 3)});
    step(3);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    exp_q.push_back('{"resume_plus1", 0, mk(1, 0, 0, 0, 3)});
    exp_q.push_back('{"resume_plus2", 0, mk(1, 0, 0, 0, 4)});
    for (int i = 0; i < 2; i++) begin
      step(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    end
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b1;
    clear      = 1'b1;
    exp_q.push_back('{"clear_priority", 0, mk(0, 0, 0, 0, 0)});
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    start_run();
    exp_q.push_back('{"presc_zeroed_3", 0, mk(1, 0, 0, 0, 0)});
    exp_q.push_back('{"presc_zeroed_4", 0, mk(1, 0, 0, 0, 1)});
    step(3);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    step(1);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  task automatic test_clear_run_and_async_reset();
    exp_t e;
    do_reset();
    start_run();
    step(20);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_q.push_back('{"clear_in_run", 0, mk(1, 0, 0, 0, 5)});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    exp_q.push_back('{"at_00_07", 0, mk(1, 0, 0, 0, 7)});
    step(7);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    #1 rst_n = 1'b0;
    exp_q.push_back('{"async_reset", 0, mk(0, 0, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    start_stop = 1'b1;
    exp_q.push_back('{"held_ss_run", 0, mk(1, 0, 0, 0, 0)});
    exp_q.push_back('{"held_ss_pause", 0, mk(0, 0, 0, 0, 0)});
    exp_q.push_back('{"held_ss_run2", 0, mk(1, 0, 0, 0, 0)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    end
    start_stop = 1'b0;
  endtask

  task automatic test_lap();
    exp_t e;
    do_reset();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    exp_q.push_back('{"lap_idle_ignored", 0, mk(0, 0, 0, 0, 0)});
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    start_run();
    step(20);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
`ifdef TIMER_CTRL_LAP_EN
    exp_q.push_back('{"lap_frozen", 0, mk(1, 0, 1, 0, 5)});
    exp_q.push_back('{"lap_hold_3_ticks", 0, mk(1, 0, 1, 0, 5)});
    exp_q.push_back('{"lap_release", 0, mk(1, 0, 0, 0, 8)});
`else
    exp_q.push_back('{"lap_ignored", 0, mk(1, 0, 0, 0, 5)});
    exp_q.push_back('{"lap_live", 0, mk(1, 0, 0, 0, 8)});
    exp_q.push_back('{"lap_live_again", 0, mk(1, 0, 0, 0, 8)});
`endif
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    step(11);
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (obs !== e.v) begin errors++; $display("[TB] FAIL %s: got %h want %h", e.name, obs, e.v); end
  endtask

  initial begin
    $display("[TB] timer_ctrl bench start");
    test_reset();
    test_start_count();
    test_minute_carry();
    test_pause_resume_clear();
    test_clear_run_and_async_reset();
    test_back_to_back();
    test_lap();
    test_rollover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, meaning clk cycles per 1-second tick (legal range >= 2).
REQ-002 SHALL have port clk  input  1  meaning system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-004 SHALL have port start_stop  input  1  meaning single-cycle pulse: start, pause or resume.
REQ-005 SHALL have port clear  input  1  meaning single-cycle pulse: return to zero when paused.
REQ-006 SHALL have port lap  input  1  meaning single-cycle pulse that toggles display freeze.
REQ-007 SHALL have port running  output  1  meaning high while in RUN.
REQ-008 SHALL have port sec_bcd  output  7  meaning displayed seconds: [6:4] tens 0-5, [3:0] ones 0-9.
REQ-009 SHALL have port min_bcd  output  7  meaning displayed minutes, same encoding.
REQ-010 SHALL have port rollover  output  1  meaning one-cycle pulse on 59:59 -> 00:00.
REQ-011 SHALL have port frozen  output  1  meaning high while display is lap-frozen.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, PAUSE.
REQ-013 SHALL transition IDLE->RUN, RUN->PAUSE, PAUSE->RUN on start_stop.
REQ-014 SHALL, on clear in PAUSE, enter IDLE and zero prescaler, seconds, minutes and freeze.
REQ-015 SHALL ignore clear in RUN and IDLE.
REQ-016 SHALL, when start_stop and clear coincide in PAUSE, give clear priority (next state IDLE).
REQ-017 SHALL advance prescaler 0..TICK_DIV-1 only in RUN, wrapping to 0; value held in PAUSE.
REQ-018 SHALL assert internal tick for the single cycle prescaler equals TICK_DIV-1 in RUN.
REQ-019 SHALL increment seconds on tick; seconds 59 wraps to 00 and increments minutes in the same cycle.
REQ-020 SHALL wrap minutes 59 to 00 and pulse rollover for exactly one cycle, coincident with the 59:59->00:00 count update.
REQ-021 SHALL register counts; updated value visible the cycle after the tick cycle.
REQ-022 SHALL keep every BCD digit legal at all times (ones never exceeds 9, tens never exceeds 5).
REQ-023 SHALL drive running combinationally from the state register (high in RUN only).
REQ-024 SHALL ignore start_stop held high beyond one cycle except as repeated pulses (each high cycle is one event).

Reset
REQ-025 SHALL, on rst_n low, asynchronously enter IDLE with prescaler 0, sec_bcd 7'h00, min_bcd 7'h00, running 0, rollover 0, frozen 0.
REQ-026 SHALL, on reset asserted mid-RUN, discard all progress; no rollover pulse issued.
REQ-027 SHALL respond to start_stop no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL compile lap freeze only when macro TIMER_CTRL_LAP_EN is defined.
REQ-029 SHALL, with TIMER_CTRL_LAP_EN, toggle frozen on lap in RUN or PAUSE; while frozen, sec_bcd/min_bcd hold the snapshot taken in the lap cycle and counting continues internally; unfreeze shows live counts next cycle; lap in IDLE ignored.
REQ-030 SHALL, without TIMER_CTRL_LAP_EN, keep lap port present but ignored, frozen tied 0, display always live.

Structure
REQ-031 SHALL place state encoding (IDLE/RUN/PAUSE) and BCD digit limits (9, 5) in shared package timer_pkg.
REQ-032 SHALL implement seconds and minutes as two instances of sub-module mod60 (en-gated BCD 00-59 counter, tc high when count 59 and en), minutes en = seconds tc.
REQ-033 SHALL keep the prescaler and FSM in timer_ctrl; display freeze register likewise.

Verification (TICK_DIV=4)
REQ-034 SHALL check: reset release, start_stop at cycle 5 -> running=1 cycle 6, sec_bcd=7'h01 after 4 further cycles, 7'h02 after 8.
REQ-035 SHALL check: run to 00:59 then one tick -> sec_bcd=7'h00, min_bcd=7'h01 same cycle.
REQ-036 SHALL check: run to 59:59 then one tick -> 00:00 and rollover high exactly one cycle.
REQ-037 SHALL check: pause at 00:03 with prescaler 2, resume -> next increment 2 cycles after resume; clear+start_stop together in PAUSE -> IDLE, 00:00.
REQ-038 SHALL check: clear in RUN ignored; rst_n low mid-RUN at 00:07 -> immediate 00:00, running=0 without waiting for clk.
REQ-039 SHALL check (TIMER_CTRL_LAP_EN): lap at 00:05 -> display holds 00:05 for 3 ticks, second lap -> displays 00:08, frozen 1 then 0.
